// File: rtl/mybusmatrix_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mybusmatrix_arb_pkg
//  Description : Shared AHB encodings and burst-length helper for the
//                parametrised bus-matrix output-stage arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mybusmatrix_arb_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HBURST encodings
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Remaining beats after the first one of a burst (length - 1).
   // Undefined-length INCR and SINGLE never hold the grant.
   function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
      logic [3:0] beats;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4  : beats = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8  : beats = 4'd7;
         HBURST_WRAP16, HBURST_INCR16 : beats = 4'd15;
         HBURST_SINGLE, HBURST_INCR   : beats = 4'd0;
         default                      : beats = 4'd0;
      endcase
      return beats;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mybusmatrix_arb_param_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mybusmatrix_rr_pick
//  Description : Combinational request picker. Fixed mode returns the lowest
//                set request; rotating mode returns the first set request
//                after the start pointer, wrapping modulo NUM_PORTS.
//  Revision    : 1.0 - initial release
// ============================================================================
module mybusmatrix_rr_pick #(
   parameter int NUM_PORTS = 5,
   parameter int PORT_W    = 3
) (
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [PORT_W-1:0]    i_start,
   input  logic                 i_mode,
   output logic [PORT_W-1:0]    o_idx,
   output logic                 o_valid
);

   int                   w_pos;
   logic [NUM_PORTS-1:0] w_shifted;

   // Scan candidates in priority order and keep the first one requesting
   always_comb begin
      o_idx     = '0;
      o_valid   = 1'b0;
      w_pos     = 0;
      w_shifted = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (i_mode) begin
            w_pos = (int'(i_start) + 1 + k) % NUM_PORTS;
         end else begin
            w_pos = k;
         end
         w_shifted = i_req >> w_pos;
         if (!o_valid && w_shifted[0]) begin
            o_valid = 1'b1;
            o_idx   = PORT_W'(w_pos);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mybusmatrix_arb_param.sv
`default_nettype none
// ============================================================================
//  Module      : mybusmatrix_arb_param
//  Description : Output-stage arbiter for one slave port of the AHB bus
//                matrix. Masked connectivity, fixed or round-robin policy,
//                lock hold and defined-length burst hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module mybusmatrix_arb_param
   import mybusmatrix_arb_pkg::*;
#(
   parameter int                   NUM_PORTS  = 5,
   parameter int                   PORT_W     = 3,
   parameter logic [NUM_PORTS-1:0] PORT_MASK  = 5'b11100,
   parameter int                   ARB_MODE   = 0,
   parameter int                   BURST_HOLD = 1
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req_port,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic                 no_port,
   output logic                 grant_chg
);

   logic [PORT_W-1:0]    r_cur;
   logic [PORT_W-1:0]    r_rr_ptr;
   logic                 r_no_port;
   logic                 r_grant_chg;
   logic [3:0]           r_beat_cnt;

   logic [NUM_PORTS-1:0] w_req_eff;
   logic                 w_active;
   logic [3:0]           w_beat_next;
   logic                 w_burst_hold;
   logic [PORT_W-1:0]    w_pick_idx;
   logic                 w_pick_valid;
   logic [PORT_W-1:0]    w_cur_next;
   logic                 w_no_port_next;

   assign w_active = HSELM & (HTRANSM != HTRANS_IDLE);

   // The current owner keeps requesting while its transfer is still active
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req_eff
      assign w_req_eff[i] = PORT_MASK[i] &
                            (req_port[i] | ((r_cur == PORT_W'(i)) & w_active));
   end

   mybusmatrix_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
   ) u_pick (
      .i_req   (w_req_eff),
      .i_start (r_rr_ptr),
      .i_mode  (ARB_MODE != 0),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   // Beat count after the phase presented now is accepted
   always_comb begin
      w_beat_next = r_beat_cnt;
      if (HSELM) begin
         case (HTRANSM)
            HTRANS_NONSEQ : w_beat_next = burst_beats(HBURSTM);
            HTRANS_SEQ    : if (r_beat_cnt != 4'd0) w_beat_next = r_beat_cnt - 4'd1;
            HTRANS_BUSY   : w_beat_next = r_beat_cnt;
            HTRANS_IDLE   : w_beat_next = 4'd0;
            default       : w_beat_next = r_beat_cnt;
         endcase
      end
   end

   // Hold is judged on the post-acceptance count: a NONSEQ that starts a
   // defined burst keeps its owner, and the last SEQ (1 -> 0) re-arbitrates
   // on that same edge.
   assign w_burst_hold = (BURST_HOLD != 0) && (w_beat_next != 4'd0) && w_active;

   // Next owner selection in priority order: lock, burst, request, slave busy
   always_comb begin
      w_cur_next     = r_cur;
      w_no_port_next = r_no_port;
      if (HMASTLOCKM) begin
         w_cur_next = r_cur;
      end else if (w_burst_hold) begin
         w_cur_next = r_cur;
      end else if (w_pick_valid) begin
         w_cur_next     = w_pick_idx;
         w_no_port_next = 1'b0;
      end else if (HSELM) begin
         w_cur_next = r_cur;
      end else begin
         w_no_port_next = 1'b1;
      end
   end

   // Arbitration state, advanced only when the slave accepts a transfer
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cur       <= '0;
         r_no_port   <= 1'b1;
         r_grant_chg <= 1'b0;
         r_beat_cnt  <= 4'd0;
         r_rr_ptr    <= PORT_W'(NUM_PORTS - 1);
      end else if (HREADYM) begin
         r_cur       <= w_cur_next;
         r_no_port   <= w_no_port_next;
         r_grant_chg <= (w_cur_next != r_cur);
         r_beat_cnt  <= w_beat_next;
         if ((w_cur_next != r_cur) && !w_no_port_next) begin
            r_rr_ptr <= w_cur_next;
         end
      end else begin
         r_grant_chg <= 1'b0;
      end
   end

   assign addr_in_port = r_cur;
   assign no_port      = r_no_port;
   assign grant_chg    = r_grant_chg;

endmodule
`default_nettype wire

// File: tb/tb_mybusmatrix_arb_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mybusmatrix_arb_param
//  Description : Self-checking bench. Three arbiters share one stimulus
//                stream: default (fixed, burst hold), round-robin, and
//                fixed without burst hold. Expected {addr,no_port,grant_chg}
//                triples are queued with each stimulus step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mybusmatrix_arb_param;
   import mybusmatrix_arb_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESETn;
   logic [4:0] req_port;
   logic       HREADYM;
   logic       HSELM;
   logic [1:0] HTRANSM;
   logic [2:0] HBURSTM;
   logic       HMASTLOCKM;

   logic [2:0] a_addr [3];
   logic       a_nop  [3];
   logic       a_chg  [3];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [4:0] req;
      logic       sel;
      logic [1:0] trans;
      logic [2:0] burst;
      logic       rdy;
      logic       lock;
   } stim_t;

   typedef struct {
      string      name;
      logic [2:0] chk;
      logic [4:0] v0;
      logic [4:0] v1;
      logic [4:0] v2;
   } exp_t;

   stim_t stim_q[$];
   exp_t  sb[$];

   always #5 HCLK = ~HCLK;

   mybusmatrix_arb_param dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
      .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
      .addr_in_port(a_addr[0]), .no_port(a_nop[0]), .grant_chg(a_chg[0])
   );

   mybusmatrix_arb_param #(.ARB_MODE(1)) dut_rr (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
      .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
      .addr_in_port(a_addr[1]), .no_port(a_nop[1]), .grant_chg(a_chg[1])
   );

   mybusmatrix_arb_param #(.BURST_HOLD(0)) dut_nh (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
      .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
      .addr_in_port(a_addr[2]), .no_port(a_nop[2]), .grant_chg(a_chg[2])
   );

   function automatic logic [4:0] ex(input int a, input bit n, input bit c);
      logic [31:0] av;
      av = a;
      return {av[2:0], n, c};
   endfunction

   // Queue one stimulus step together with the outputs expected after it
   task automatic push(input string nm, input logic [4:0] rq, input logic sl,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rd,
                       input logic lk, input logic [2:0] ck,
                       input logic [4:0] e0, input logic [4:0] e1, input logic [4:0] e2);
      stim_t s;
      exp_t  e;
      s.req = rq; s.sel = sl; s.trans = tr; s.burst = bu; s.rdy = rd; s.lock = lk;
      e.name = nm; e.chk = ck; e.v0 = e0; e.v1 = e1; e.v2 = e2;
      stim_q.push_back(s);
      sb.push_back(e);
   endtask

   task automatic apply();
      stim_t s;
      s = stim_q.pop_front();
      req_port = s.req; HSELM = s.sel; HTRANSM = s.trans;
      HBURSTM = s.burst; HREADYM = s.rdy; HMASTLOCKM = s.lock;
   endtask

   task automatic idle_inputs();
      req_port = '0; HSELM = 1'b0; HTRANSM = HTRANS_IDLE;
      HBURSTM = HBURST_SINGLE; HREADYM = 1'b1; HMASTLOCKM = 1'b0;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      idle_inputs();
      @(posedge HCLK); @(posedge HCLK); #1;
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      logic [4:0] g;
      exp_t       e;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         g = {a_addr[i], a_nop[i], a_chg[i]};
         n_checks++;
         if (g !== ex(0, 1, 0))
            $display("FAIL reset_values inst%0d: got addr=%0d no_port=%0b grant_chg=%0b, want addr=0 no_port=1 grant_chg=0",
                     i, g[4:2], g[1], g[0]);
         else n_pass++;
      end
      push("reset_idle", 5'b00000, 0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 3'b111,
           ex(0,1,0), ex(0,1,0), ex(0,1,0));
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_fixed();
      logic [4:0] g;
      exp_t       e;
      do_reset();
      push("fix_grant2",  5'b11100, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(2,0,1), 0, 0);
      push("fix_drop2",   5'b11000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(3,0,1), 0, 0);
      push("fix_keep3",   5'b11000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("fix_curterm", 5'b00000, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("fix_release", 5'b00000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(3,1,0), 0, 0);
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_mask();
      logic [4:0] g;
      exp_t       e;
      do_reset();
      push("mask_ign1", 5'b00011, 0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 3'b111, ex(0,1,0), ex(0,1,0), ex(0,1,0));
      push("mask_ign2", 5'b00011, 0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 3'b011, ex(0,1,0), ex(0,1,0), 0);
      push("mask_g2",   5'b00111, 0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 3'b011, ex(2,0,1), ex(2,0,1), 0);
      push("mask_keep", 5'b00011, 0, HTRANS_IDLE, HBURST_SINGLE, 1, 0, 3'b011, ex(2,1,0), ex(2,1,0), 0);
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_round_robin();
      logic [4:0] g;
      exp_t       e;
      do_reset();
      push("rr_1", 5'b11100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 3'b011, ex(2,0,1), ex(2,0,1), 0);
      push("rr_2", 5'b11100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 3'b011, ex(2,0,0), ex(3,0,1), 0);
      push("rr_3", 5'b11100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 3'b010, 0, ex(4,0,1), 0);
      push("rr_4", 5'b11100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 3'b010, 0, ex(2,0,1), 0);
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_burst_hold();
      logic [4:0] g;
      exp_t       e;
      do_reset();
      push("bh_grant3", 5'b01000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b101, ex(3,0,1), 0, ex(3,0,1));
      push("bh_nonseq", 5'b01100, 1, HTRANS_NONSEQ, HBURST_INCR4,  1, 0, 3'b101, ex(3,0,0), 0, ex(2,0,1));
      push("bh_seq1",   5'b01100, 1, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("bh_seq2",   5'b01100, 1, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("bh_seq3",   5'b01100, 1, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 3'b001, ex(2,0,1), 0, 0);
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_stall_and_idle();
      logic [4:0] g;
      exp_t       e;
      do_reset();
      push("st_grant3", 5'b01000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(3,0,1), 0, 0);
      push("st_nonseq", 5'b01100, 1, HTRANS_NONSEQ, HBURST_INCR4,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      for (int k = 0; k < 3; k++)
         push("st_wait",  5'b01100, 1, HTRANS_SEQ,  HBURST_INCR4,  0, 0, 3'b001, ex(3,0,0), 0, 0);
      push("st_busy",   5'b01100, 1, HTRANS_BUSY,   HBURST_INCR4,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("st_seq1",   5'b01100, 1, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("st_seq2",   5'b01100, 1, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("st_seq3",   5'b01100, 1, HTRANS_SEQ,    HBURST_INCR4,  1, 0, 3'b001, ex(2,0,1), 0, 0);
      push("et_grant3", 5'b01000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(3,0,1), 0, 0);
      push("et_nonseq", 5'b01100, 1, HTRANS_NONSEQ, HBURST_INCR8,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("et_seq",    5'b01100, 1, HTRANS_SEQ,    HBURST_INCR8,  1, 0, 3'b001, ex(3,0,0), 0, 0);
      push("et_idle",   5'b01100, 1, HTRANS_IDLE,   HBURST_INCR8,  1, 0, 3'b001, ex(2,0,1), 0, 0);
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
   endtask

   task automatic test_lock_and_reset();
      logic [4:0] g;
      exp_t       e;
      do_reset();
      push("lk_grant3",  5'b01000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(3,0,1), 0, 0);
      push("lk_hold1",   5'b01100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 1, 3'b001, ex(3,0,0), 0, 0);
      push("lk_hold2",   5'b01100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 1, 3'b001, ex(3,0,0), 0, 0);
      push("lk_nonseq",  5'b01100, 1, HTRANS_NONSEQ, HBURST_INCR4,  1, 1, 3'b001, ex(3,0,0), 0, 0);
      for (int k = 0; k < 3; k++)
         push("lk_seq",  5'b01100, 1, HTRANS_SEQ,    HBURST_INCR4,  1, 1, 3'b001, ex(3,0,0), 0, 0);
      push("lk_unlock",  5'b01100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 0, 3'b001, ex(2,0,1), 0, 0);
      push("rs_grant3",  5'b01000, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 0, 3'b001, ex(3,0,1), 0, 0);
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
      // Start a burst, then pulse reset between clock edges
      req_port = 5'b01100; HSELM = 1'b1; HTRANSM = HTRANS_NONSEQ; HBURSTM = HBURST_INCR4;
      #2 HRESETn = 1'b0;
      #1;
      g = {a_addr[0], a_nop[0], a_chg[0]};
      n_checks++;
      if (g !== ex(0, 1, 0))
         $display("FAIL async_reset: got addr=%0d no_port=%0b grant_chg=%0b, want addr=0 no_port=1 grant_chg=0",
                  g[4:2], g[1], g[0]);
      else n_pass++;
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      push("rs_after", 5'b00000, 1, HTRANS_SEQ, HBURST_INCR4, 1, 0, 3'b001, ex(0,1,0), 0, 0);
      while (stim_q.size() != 0) begin
         apply(); @(posedge HCLK); #1; e = sb.pop_front();
         for (int i = 0; i < 3; i++) if (e.chk[i]) begin
            g = {a_addr[i], a_nop[i], a_chg[i]};
            n_checks++;
            if (g !== ((i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2))
               $display("FAIL %s inst%0d: got addr/nop/chg=%b want %b", e.name, i, g,
                        (i == 0) ? e.v0 : (i == 1) ? e.v1 : e.v2);
            else n_pass++;
         end
      end
   endtask

   initial begin
      HRESETn = 1'b0;
      idle_inputs();
      test_reset();
      test_fixed();
      test_mask();
      test_round_robin();
      test_burst_hold();
      test_stall_and_idle();
      test_lock_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mybusmatrix_arb_param.md
# mybusmatrix_arb_param

Parametrised output-stage arbiter for the generated AHB bus matrices: one instance per slave output port, it selects which input port drives the shared slave. It generalises the fixed-priority sparse arbiter in four ways: a configurable port count, a connectivity mask, a selectable fixed or round-robin policy, and burst-hold so defined-length bursts are never split. Its outputs feed the output-stage address/data muxes exactly as the existing per-slave arbiters do.

## Interface
Parameters:
- NUM_PORTS, 5, number of input ports (2..16)
- PORT_W, 3, width of port index; must satisfy 2**PORT_W >= NUM_PORTS
- PORT_MASK, 5'b11100, bit i = 1 when input port i connects to this slave; unmasked requests are ignored
- ARB_MODE, 0, 0 = fixed priority (port 0 highest), 1 = round-robin
- BURST_HOLD, 1, 1 = keep the grant until a defined-length burst completes

Ports:
- HCLK  input  1  AHB clock
- HRESETn  input  1  reset, asynchronous, active-low
- req_port  input  NUM_PORTS  per-port request
- HREADYM  input  1  slave-side transfer done
- HSELM  input  1  slave select of the current address phase
- HTRANSM  input  2  transfer type of the current address phase
- HBURSTM  input  3  burst type of the current address phase
- HMASTLOCKM  input  1  locked transfer
- addr_in_port  output  PORT_W  selected port index
- no_port  output  1  no port selected
- grant_chg  output  1  one-cycle pulse: addr_in_port changed on the last update

## Operation
- All state updates only on HCLK rising edges with HREADYM=1; otherwise all state holds.
- Effective request r[i] = PORT_MASK[i] & (req_port[i] | (cur==i & HSELM & HTRANSM!=IDLE)).
- Next-grant priority, highest first:
  1. HMASTLOCKM=1: hold cur.
  2. Burst hold active (BURST_HOLD & beat_cnt!=0 & HSELM & HTRANSM!=IDLE): hold cur.
  3. Any r set: ARB_MODE=0 picks the lowest index. ARB_MODE=1 picks the first set bit searching rr_ptr+1 upward, wrapping modulo NUM_PORTS.
  4. HSELM=1: hold cur.
  5. Otherwise: no_port_next=1, cur held.
- rr_ptr is loaded with the new grant only when the grant changes to a different port and no_port_next=0.
- Beat counter, 4 bits, advanced on an accepted phase (HREADYM & HSELM):
  - NONSEQ loads len−1: INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15, SINGLE/INCR=0.
  - SEQ decrements, saturating at 0.
  - BUSY holds.
  - IDLE clears to 0 (early termination).
- grant_chg = registered (addr_in_port_next != cur) on an update; otherwise 0.
- If a masked-off port requests, its request has no effect on any state.

## Timing
- Reset values: addr_in_port=0, no_port=1, grant_chg=0, beat_cnt=0, rr_ptr=NUM_PORTS-1, so port 0 is searched first.
- Reset asserted mid-burst returns all state to reset values immediately (asynchronous).
- Grant latency is 1 cycle: a request sampled at an edge with HREADYM=1 appears on addr_in_port after that edge.
- HREADYM=0 stalls arbitration indefinitely, with no lost or duplicated beat counts.
- Simultaneous lock and burst hold: lock dominates, and the counter still tracks beats.
- Last SEQ beat accepted (cnt 1→0): re-arbitration is permitted at that same edge.

## Structure
- Package mybusmatrix_arb_pkg holds:
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ
  - HBURST encodings
  - function burst_beats(hburst) returning len−1
- One sub-module, mybusmatrix_rr_pick: combinational, parametrised NUM_PORTS. Inputs are the request vector, start pointer and mode; outputs are the index and a valid flag.

## Test plan
- **Fixed priority.** Defaults, ARB_MODE=0, req_port=5'b11100 with HREADYM=1 → addr_in_port=2, no_port=0 the next cycle. Drop req 2 while the slave is IDLE → port 3.
- **Mask.** req_port=5'b00011 only → ports 0/1 ignored. no_port stays 1 when HSELM=0, and addr_in_port is unchanged.
- **Round-robin.** ARB_MODE=1, ports 2,3,4 request continuously with SINGLE transfers → grants cycle 2,3,4,2 on successive updates, with grant_chg=1 each time.
- **Burst hold.** Port 3 issues an INCR4 (NONSEQ+3 SEQ) while port 2 requests → port 3 held 4 beats, port 2 granted after the last SEQ. With BURST_HOLD=0, port 2 wins after the NONSEQ.
- **Stalls and early termination.** Insert HREADYM=0 for 3 cycles mid-burst plus one BUSY → no grant change and beat_cnt unchanged. An IDLE mid-burst releases the grant at the next update.
- **Lock and reset.** HMASTLOCKM=1 with higher-priority requests → grant held. HRESETn pulsed mid-burst → addr_in_port=0, no_port=1, grant_chg=0 asynchronously.
